id_stage: RTL
=============

# id_stage

Parametrised, pipelined RV32I/RV64I decode stage. Sits between fetch and execute, accepts one instruction per cycle over a valid/ready handshake, and emits a registered decode packet. Also resolves branches and jumps locally, issues a registered one-cycle redirect, squashes wrong-path fetches, and inserts load-use bubbles.

## Interface
- XLEN, 32: datapath width, 32 or 64.
- KILL_CYCLES, 1: cycles of wrong-path squash after a redirect, 1..7.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid / in_ready  in / out  1  fetch handshake.
- in_pc  in  XLEN  instruction address.
- in_inst  in  32  instruction word.
- rs1_addr, rs2_addr  out  5  combinational `in_inst[19:15]`, `in_inst[24:20]` to the register file.
- rs1_data, rs2_data  in  XLEN  already-forwarded operands, same cycle.
- out_valid / out_ready  out / in  1  execute handshake.
- out_pc, out_imm, out_rs1_data, out_rs2_data  out  XLEN  registered packet fields.
- out_rd  out  5  destination register.
- out_alu_op  out  5  `id_pkg` ALU code.
- out_alu_src_1  out  1  operand 1 select: 0 = rs1, 1 = pc.
- out_alu_src_2  out  1  operand 2 select: 0 = rs2, 1 = imm.
- out_mem_op  out  6  memory operation: [5] load, [4] store, [3] unsigned, [2] 0, [1:0] size (00 = B, 01 = H, 10 = W, 11 = D).
- out_reg_we, out_illegal  out  1  register write enable; illegal-instruction flag.
- redirect  out  1  registered one-cycle pulse.
- redirect_addr  out  XLEN  target with bit 0 cleared.

## Operation
- **Accept:** `fire_in = in_valid & in_ready`.
- **in_ready** = `!stall & (!out_valid | out_ready)`, or 1 whenever `kill_cnt != 0`.
- **Classes:** decoded from `in_inst[6:2]`: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, plus OP-IMM-32/OP-32 when XLEN = 64. Every other class is illegal.
- **Immediates:** U, J, I, B and S formats, sign-extended to XLEN.
- **LUI:** `alu_op = PASS_B`, src2 = imm.
- **AUIPC:** ADD, src1 = pc, src2 = imm.
- **JAL/JALR:** ADD, src1 = pc, `out_imm = 4` (link value).
- **Branch compare:** uses rs1_data/rs2_data at XLEN width: eq, signed lt, unsigned lt by funct3 (000, 001, 100, 101, 110, 111). funct3 010/011 are illegal.
- **Target:** `(JALR ? rs1_data : in_pc) + imm`, bit 0 cleared, mod 2^XLEN.
- **Taken branch or jump on fire_in:**
  - next cycle: `redirect = 1` and redirect_addr is valid;
  - kill_cnt loads KILL_CYCLES.
- **Squash:** while `kill_cnt != 0`, each cycle decrements kill_cnt. Any instruction presented is accepted and dropped, with no packet, no redirect and no stall.
- **Load-use stall:** `stall = out_valid & out_mem_op[5] & out_rd != 0 & out_rd ∈ {used rs1, used rs2}`.
  - "Used" is per class; U/J classes use neither.
  - While stalled, the packet drains on out_ready; out_valid falls the next cycle (bubble).
- **Illegal instruction:** packet issued with `out_illegal = 1`, `reg_we = 0`, `mem_op = 0`; no redirect.
- **reg_we = 0** for branch, store, illegal, and `rd = x0`.

## Timing
- **Latency:** 1 cycle from fire_in to out_valid. Throughput 1/cycle.
- **Hold:** the packet is held stable while `out_valid & !out_ready`.
- **Reset values:** every output is 0; kill_cnt = 0.
  - Reset during a stall, squash or pending redirect clears all of them. Reset has priority over every other event.
- **Redirect in the same cycle as a stall:** not possible. A stalled instruction is not accepted, so it is resolved when it is accepted.
- **Redirect while out_ready is low:** the redirect pulse is still issued one cycle after fire_in. Packet backpressure does not delay it.
- **kill_cnt saturation:** it never wraps. A taken jump cannot be accepted while `kill_cnt != 0`, because that instruction is squashed.

## Configuration
- **RV_M_EN defined:**
  - OP with `funct7 = 0000001` decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
  - with XLEN = 64, OP-32 decodes the W variants.
- **RV_M_EN undefined:** those encodings are illegal.

## Structure
- Package `id_pkg` holds:
  - ALU op constants (ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B=10, M ops 16..23, W-suffix flag);
  - mem_op field positions;
  - opcode class constants.
- One sub-module, `id_br_cmp`: XLEN-parametrised comparator plus target adder, combinational.

## Test plan
- **ADDI:** `in_inst = 0x00500093`, `rs1_data = 7`, out_ready = 1 → next cycle out_valid = 1, `out_rd = 1`, `out_imm = 5`, ADD, `src2 = 1`, `reg_we = 1`.
- **Taken BEQ:** `0x00208463` at pc `0x100`, rs1 = rs2 = 3 → one cycle later redirect = 1, `redirect_addr = 0x108`. The next fetched instruction is dropped (KILL_CYCLES = 1).
- **Load-use:** LW x5 then ADD x6,x5,x1 back-to-back → in_ready is low for one cycle, a bubble (out_valid = 0) appears, then the ADD issues.
- **Backpressure:** out_ready = 0 for 3 cycles → packet is held, in_ready = 0, no instruction is lost.
- **MUL:** `0x02208033`
  - with RV_M_EN → `out_alu_op = MUL`;
  - without RV_M_EN → `out_illegal = 1`, `reg_we = 0`.
- **Reset mid-squash:** rst in the cycle after a JAL redirect → all outputs 0, and the next instruction is decoded normally.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants, decode-result struct and small helpers for id_stage.
// Optional RV_M_EN build macro enables the M-extension encodings.
package id_pkg;

  localparam int unsigned ALU_W  = 5;
  localparam int unsigned MEM_W  = 6;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned KILL_W = 3;

  localparam logic [ALU_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SLL    = 5'd2;
  localparam logic [ALU_W-1:0] ALU_SLT    = 5'd3;
  localparam logic [ALU_W-1:0] ALU_SLTU   = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_W-1:0] ALU_OR     = 5'd8;
  localparam logic [ALU_W-1:0] ALU_AND    = 5'd9;
  localparam logic [ALU_W-1:0] ALU_PASS_B = 5'd10;
  // Base-ISA word ops have dedicated codes; M ops carry ALU_W_FLAG instead.
  localparam logic [ALU_W-1:0] ALU_ADDW   = 5'd11;
  localparam logic [ALU_W-1:0] ALU_SUBW   = 5'd12;
  localparam logic [ALU_W-1:0] ALU_SLLW   = 5'd13;
  localparam logic [ALU_W-1:0] ALU_SRLW   = 5'd14;
  localparam logic [ALU_W-1:0] ALU_SRAW   = 5'd15;
  localparam logic [ALU_W-1:0] ALU_MUL    = 5'd16;
  localparam logic [ALU_W-1:0] ALU_MULH   = 5'd17;
  localparam logic [ALU_W-1:0] ALU_MULHSU = 5'd18;
  localparam logic [ALU_W-1:0] ALU_MULHU  = 5'd19;
  localparam logic [ALU_W-1:0] ALU_DIV    = 5'd20;
  localparam logic [ALU_W-1:0] ALU_DIVU   = 5'd21;
  localparam logic [ALU_W-1:0] ALU_REM    = 5'd22;
  localparam logic [ALU_W-1:0] ALU_REMU   = 5'd23;
  localparam logic [ALU_W-1:0] ALU_W_FLAG = 5'b01000;

  localparam int unsigned MEM_LOAD  = 5;
  localparam int unsigned MEM_STORE = 4;
  localparam int unsigned MEM_UNS   = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD      = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_STORE     = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_OP        = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_LUI       = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 5'b01110;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JALR      = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_JAL       = 5'b11011;

  typedef struct packed {
    logic [31:0]       imm;
    logic [31:0]       br_imm;
    logic [ALU_W-1:0]  alu_op;
    logic              src1;
    logic              src2;
    logic [MEM_W-1:0]  mem_op;
    logic              reg_we;
    logic              illegal;
    logic              use_rs1;
    logic              use_rs2;
    logic              is_jal;
    logic              is_jalr;
    logic              is_branch;
  } dec_t;

  // Register/immediate ALU op selected purely by funct3 (funct7 = 0 forms).
  function automatic logic [ALU_W-1:0] base_alu(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_br_cmp.sv
// Branch condition evaluation and branch/jump target adder (combinational).
module id_br_cmp
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic            is_jalr,
  output logic            cond,
  output logic [XLEN-1:0] target
);

  logic            raw;
  logic [XLEN-1:0] sum;

  // funct3[2:1] picks the relation, funct3[0] inverts it.
  always_comb begin
    case (funct3[2:1])
      2'b00:   raw = (rs1 == rs2);
      2'b10:   raw = ($signed(rs1) < $signed(rs2));
      2'b11:   raw = (rs1 < rs2);
      default: raw = 1'b0;
    endcase
    cond   = raw ^ funct3[0];
    sum    = (is_jalr ? rs1 : pc) + imm;
    target = sum & ~XLEN'(1);
  end

endmodule

// File: rtl/id_stage.sv
// Pipelined RV32I/RV64I decode stage with local branch resolution, squash and load-use stall.
// Build macro RV_M_EN enables decoding of the M-extension.
module id_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned KILL_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_alu_op,
  output logic            out_alu_src_1,
  output logic            out_alu_src_2,
  output logic [5:0]      out_mem_op,
  output logic            out_reg_we,
  output logic            out_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_addr
);

  localparam bit RV64 = (XLEN == 64);
  localparam logic [KILL_W-1:0] KILL_LOAD = KILL_W'(KILL_CYCLES);

  dec_t              d;
  logic [OPC_W-1:0]  opc;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              shamt_ok;
  logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]   tgt_imm;
  logic [XLEN-1:0]   target;
  logic              cond;
  logic              taken;
  logic              stall;
  logic              fire_in;
  logic [KILL_W-1:0] kill_cnt;

  assign opc      = in_inst[6:2];
  assign rd       = in_inst[11:7];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign shamt_ok = RV64 || !in_inst[25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Instruction class decode; illegal encodings collapse to a bare illegal flag.
  always_comb begin
    d         = '0;
    d.illegal = (in_inst[1:0] != 2'b11);
    case (opc)
      OPC_LUI: begin
        d.alu_op = ALU_PASS_B; d.src2 = 1'b1; d.imm = imm_u; d.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        d.alu_op = ALU_ADD; d.src1 = 1'b1; d.src2 = 1'b1; d.imm = imm_u; d.reg_we = 1'b1;
      end
      OPC_JAL: begin
        d.src1 = 1'b1; d.src2 = 1'b1; d.imm = 32'd4; d.br_imm = imm_j;
        d.reg_we = 1'b1; d.is_jal = 1'b1;
      end
      OPC_JALR: begin
        d.src1 = 1'b1; d.src2 = 1'b1; d.imm = 32'd4; d.br_imm = imm_i;
        d.reg_we = 1'b1; d.use_rs1 = 1'b1; d.is_jalr = 1'b1;
        if (funct3 != 3'b000) d.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        d.alu_op = ALU_SUB; d.imm = imm_b; d.br_imm = imm_b;
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.is_branch = 1'b1;
        if (funct3[2:1] == 2'b01) d.illegal = 1'b1;
      end
      OPC_LOAD: begin
        d.src2 = 1'b1; d.imm = imm_i; d.use_rs1 = 1'b1; d.reg_we = 1'b1;
        d.mem_op = {1'b1, 1'b0, funct3[2], 1'b0, funct3[1:0]};
        if (funct3 == 3'b111 || ((funct3 == 3'b011 || funct3 == 3'b110) && !RV64))
          d.illegal = 1'b1;
      end
      OPC_STORE: begin
        d.src2 = 1'b1; d.imm = imm_s; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        d.mem_op = {1'b0, 1'b1, 1'b0, 1'b0, funct3[1:0]};
        if (funct3[2] || (funct3 == 3'b011 && !RV64)) d.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        d.src2 = 1'b1; d.imm = imm_i; d.use_rs1 = 1'b1; d.reg_we = 1'b1;
        d.alu_op = base_alu(funct3);
        if (funct3 == 3'b001 && !(in_inst[31:26] == 6'b000000 && shamt_ok))
          d.illegal = 1'b1;
        if (funct3 == 3'b101) begin
          d.alu_op = in_inst[30] ? ALU_SRA : ALU_SRL;
          if (!((in_inst[31:26] == 6'b000000 || in_inst[31:26] == 6'b010000) && shamt_ok))
            d.illegal = 1'b1;
        end
      end
      OPC_OP: begin
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.reg_we = 1'b1;
        case (funct7)
          7'b0000000: d.alu_op = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      d.alu_op = ALU_SUB;
            else if (funct3 == 3'b101) d.alu_op = ALU_SRA;
            else                       d.illegal = 1'b1;
          end
`ifdef RV_M_EN
          7'b0000001: d.alu_op = ALU_MUL | ALU_W'(funct3);
`endif
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM_32: begin
        d.src2 = 1'b1; d.imm = imm_i; d.use_rs1 = 1'b1; d.reg_we = 1'b1;
        if (!RV64) d.illegal = 1'b1;
        case (funct3)
          3'b000: d.alu_op = ALU_ADDW;
          3'b001: begin
            d.alu_op = ALU_SLLW;
            if (funct7 != 7'b0000000) d.illegal = 1'b1;
          end
          3'b101: begin
            d.alu_op = in_inst[30] ? ALU_SRAW : ALU_SRLW;
            if (funct7 != 7'b0000000 && funct7 != 7'b0100000) d.illegal = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.reg_we = 1'b1;
        if (!RV64) d.illegal = 1'b1;
        case (funct7)
          7'b0000000: begin
            if (funct3 == 3'b000)      d.alu_op = ALU_ADDW;
            else if (funct3 == 3'b001) d.alu_op = ALU_SLLW;
            else if (funct3 == 3'b101) d.alu_op = ALU_SRLW;
            else                       d.illegal = 1'b1;
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      d.alu_op = ALU_SUBW;
            else if (funct3 == 3'b101) d.alu_op = ALU_SRAW;
            else                       d.illegal = 1'b1;
          end
`ifdef RV_M_EN
          7'b0000001: begin
            d.alu_op = ALU_MUL | ALU_W_FLAG | ALU_W'(funct3);
            if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) d.illegal = 1'b1;
          end
`endif
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    if (rd == 5'd0) d.reg_we = 1'b0;
  end

  assign tgt_imm = XLEN'($signed(d.br_imm));

  id_br_cmp #(.XLEN(XLEN)) u_br_cmp (
    .rs1     (rs1_data),
    .rs2     (rs2_data),
    .pc      (in_pc),
    .imm     (tgt_imm),
    .funct3  (funct3),
    .is_jalr (d.is_jalr),
    .cond    (cond),
    .target  (target)
  );

  assign taken = d.is_jal | d.is_jalr | (d.is_branch & cond);

  // Load-use hazard against the load currently held in the output register.
  assign stall = out_valid & out_mem_op[MEM_LOAD] & (out_rd != 5'd0) &
                 ((d.use_rs1 & (out_rd == rs1_addr)) | (d.use_rs2 & (out_rd == rs2_addr)));

  assign in_ready = !rst & ((kill_cnt != '0) | (!stall & (!out_valid | out_ready)));
  assign fire_in  = in_valid & in_ready;

  // Packet register, redirect pulse and wrong-path squash counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_rd        <= '0;
      out_alu_op    <= '0;
      out_alu_src_1 <= 1'b0;
      out_alu_src_2 <= 1'b0;
      out_mem_op    <= '0;
      out_reg_we    <= 1'b0;
      out_illegal   <= 1'b0;
      redirect      <= 1'b0;
      redirect_addr <= '0;
      kill_cnt      <= '0;
    end else begin
      redirect <= 1'b0;
      if (kill_cnt != '0) begin
        kill_cnt <= kill_cnt - KILL_W'(1);
        if (out_ready) out_valid <= 1'b0;
      end else if (fire_in) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_imm       <= XLEN'($signed(d.imm));
        out_rs1_data  <= rs1_data;
        out_rs2_data  <= rs2_data;
        out_rd        <= d.reg_we ? rd : 5'd0;
        out_alu_op    <= d.alu_op;
        out_alu_src_1 <= d.src1;
        out_alu_src_2 <= d.src2;
        out_mem_op    <= d.mem_op;
        out_reg_we    <= d.reg_we;
        out_illegal   <= d.illegal;
        if (taken) begin
          redirect      <= 1'b1;
          redirect_addr <= target;
          kill_cnt      <= KILL_LOAD;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
